// File: rtl/dmem_ctrl.sv
// Data-memory responder for the MEM-stage load/store port: posted stores go into a
// small write buffer that drains into a single-port word array. Optional macro: DMEM_WBUF_FWD_EN.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LATENCY  = 2,
  parameter int WBUF_DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_wr_err,
  output logic        o_busy
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_READ_WAIT = 2'd1;
  localparam logic [1:0] S_RESP      = 2'd2;
  localparam logic [1:0] S_DRAIN     = 2'd3;

  logic [1:0]    r_state;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_rdIdx;
  logic [31:0]   r_rspData;
  logic          r_rspErr;
  logic          r_wrErr;

  logic [AW-1:0] r_wbufIdx  [WBUF_DEPTH];
  logic [31:0]   r_wbufData [WBUF_DEPTH];
  logic [31:0]   r_mem      [DEPTH_WORDS];

  logic [AW-1:0] w_wordIdx;
  logic          w_misal;
  logic          w_full;
  logic          w_empty;
  logic          w_canAccept;
  logic          w_accept;
  logic          w_push;
  logic          w_drain;
  logic [AW-1:0] w_rdAddr;
  logic [31:0]   w_memRd;
  logic          w_unusedAddr;

  assign w_wordIdx    = i_req_addr[AW+1:2];
  assign w_misal      = |i_req_addr[1:0];
  assign w_unusedAddr = ^i_req_addr[31:AW+2];
  assign w_full       = (r_count == (PW+1)'(WBUF_DEPTH));
  assign w_empty      = (r_count == '0);

  // RESP is a single-cycle exit state, so it accepts requests exactly like IDLE.
  assign w_canAccept = (r_state == S_IDLE) || (r_state == S_RESP);
  assign o_req_ready = w_canAccept && (!i_req_write || !w_full);
  assign w_accept    = i_req_valid && o_req_ready;
  assign w_push      = w_accept && i_req_write && !w_misal;
  assign w_drain     = !w_empty && !w_accept && (r_state != S_READ_WAIT);

  // Array read port with a bypass for the head entry being drained on the same edge.
  assign w_rdAddr = w_canAccept ? w_wordIdx : r_rdIdx;
  assign w_memRd  = (w_drain && (r_wbufIdx[r_head] == w_rdAddr)) ? r_wbufData[r_head]
                                                                 : r_mem[w_rdAddr];

`ifdef DMEM_WBUF_FWD_EN
  logic          w_fwdHit;
  logic [31:0]   w_fwdData;

  // Scan oldest to youngest so the youngest matching store overrides earlier ones.
  always_comb begin
    w_fwdHit  = 1'b0;
    w_fwdData = '0;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      if (((PW+1)'(k) < r_count) && (r_wbufIdx[r_head + PW'(k)] == w_wordIdx)) begin
        w_fwdHit  = 1'b1;
        w_fwdData = r_wbufData[r_head + PW'(k)];
      end
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_cnt     <= '0;
      r_rdIdx   <= '0;
      r_rspData <= '0;
      r_rspErr  <= 1'b0;
      r_wrErr   <= 1'b0;
    end else begin
      r_wrErr  <= w_accept && i_req_write && w_misal;
      r_rspErr <= 1'b0;

      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_drain) begin
        r_head <= r_head + 1'b1;
      end
      if (w_push && !w_drain) begin
        r_count <= r_count + 1'b1;
      end else if (w_drain && !w_push) begin
        r_count <= r_count - 1'b1;
      end

      case (r_state)
        S_IDLE, S_RESP: begin
          r_state <= S_IDLE;
          if (w_accept && !i_req_write) begin
            r_rdIdx <= w_wordIdx;
            if (w_misal) begin
              r_state   <= S_RESP;
              r_rspErr  <= 1'b1;
              r_rspData <= '0;
            end
`ifdef DMEM_WBUF_FWD_EN
            else if (w_fwdHit) begin
              r_state   <= S_RESP;
              r_rspData <= w_fwdData;
            end
`else
            else if (!w_empty) begin
              r_state <= S_DRAIN;
            end
`endif
            else if (RD_LATENCY == 1) begin
              r_state   <= S_RESP;
              r_rspData <= w_memRd;
            end else begin
              r_state <= S_READ_WAIT;
              r_cnt   <= CW'(RD_LATENCY - 1);
            end
          end
        end
        S_DRAIN: begin
          if (r_count == (PW+1)'(1)) begin
            if (RD_LATENCY == 1) begin
              r_state   <= S_RESP;
              r_rspData <= w_memRd;
            end else begin
              r_state <= S_READ_WAIT;
              r_cnt   <= CW'(RD_LATENCY - 1);
            end
          end
        end
        S_READ_WAIT: begin
          if (r_cnt == CW'(1)) begin
            r_state   <= S_RESP;
            r_rspData <= w_memRd;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffer storage and the array itself are not reset; only the pointers are.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_wbufIdx[r_tail]  <= w_wordIdx;
      r_wbufData[r_tail] <= i_req_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_drain) begin
      r_mem[r_wbufIdx[r_head]] <= r_wbufData[r_head];
    end
  end

  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rspData;
  assign o_rsp_err   = r_rspErr;
  assign o_wr_err    = r_wrErr;
  assign o_busy      = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: a transaction-level model predicts every output each
// cycle, and directed loads pin latency and data with hand-computed literals.
module tb_dmem_ctrl;

  localparam int DEPTH = 1024;
  localparam int RDL   = 2;
  localparam int WB    = 4;

`ifdef DMEM_WBUF_FWD_EN
  localparam int LAT_T2  = 1;
  localparam int LAT_T3A = 1;
  localparam int LAT_T4  = 2;
`else
  localparam int LAT_T2  = 3;
  localparam int LAT_T3A = 4;
  localparam int LAT_T4  = 6;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqWrite = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic        reqReady;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic        wrErr;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(RDL), .WBUF_DEPTH(WB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (reqValid),
    .o_req_ready (reqReady),
    .i_req_write (reqWrite),
    .i_req_addr  (reqAddr),
    .i_req_wdata (reqWdata),
    .o_rsp_valid (rspValid),
    .o_rsp_rdata (rspRdata),
    .o_rsp_err   (rspErr),
    .o_wr_err    (wrErr),
    .o_busy      (busy)
  );

  // Model: pending stores as a queue, the array as a plain word array, and one
  // outstanding load described by its accept cycle, response cycle and payload.
  typedef struct {
    int          idx;
    logic [31:0] data;
  } entT;

  entT         mQ[$];
  logic [31:0] mMem [DEPTH];
  bit          mKnown [DEPTH];
  int          cyc = 0;
  int          pAccept = -1;
  int          pRespAt = -1;
  int          pReadFrom = -1;
  int          wrErrAt = -1;
  logic [31:0] pData = '0;
  bit          pErr = 1'b0;
  bit          pKnown = 1'b1;

  function automatic bit expReady(input bit wr);
    return !(pRespAt > cyc) && (!wr || (mQ.size() < WB));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit   acc, misal, inReadWait, drn, hit;
    int   idx;
    entT  e;
    misal      = (reqAddr[1:0] != 2'b00);
    idx        = int'(reqAddr >> 2) % DEPTH;
    acc        = reqValid && expReady(reqWrite);
    inReadWait = (cyc >= pReadFrom) && (cyc < pRespAt);
    drn        = (mQ.size() > 0) && !acc && !inReadWait;
    if (acc && !reqWrite) begin
      pAccept = cyc;
      if (misal) begin
        pErr = 1'b1; pData = '0; pKnown = 1'b1;
        pRespAt = cyc + 1; pReadFrom = pRespAt;
      end else begin
        hit = 1'b0;
        pErr = 1'b0;
        for (int i = mQ.size() - 1; i >= 0 && !hit; i--) begin
          if (mQ[i].idx == idx) begin
            hit = 1'b1; pData = mQ[i].data; pKnown = 1'b1;
          end
        end
        if (!hit) begin
          pData = mMem[idx]; pKnown = mKnown[idx];
        end
`ifdef DMEM_WBUF_FWD_EN
        if (hit) begin
          pRespAt = cyc + 1; pReadFrom = pRespAt;
        end else begin
          pRespAt = cyc + RDL; pReadFrom = pRespAt - RDL + 1;
        end
`else
        pRespAt = cyc + mQ.size() + RDL;
        pReadFrom = pRespAt - RDL + 1;
`endif
      end
    end
    if (drn) begin
      e = mQ.pop_front();
      mMem[e.idx] = e.data;
      mKnown[e.idx] = 1'b1;
    end
    if (acc && reqWrite) begin
      if (misal) begin
        wrErrAt = cyc + 1;
      end else begin
        e.idx = idx; e.data = reqWdata;
        mQ.push_back(e);
      end
    end
    cyc++;
  endtask

  task automatic modelLoop();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mQ.delete();
        pAccept = -1; pRespAt = -1; pReadFrom = -1; wrErrAt = -1; pErr = 1'b0;
      end else begin
        modelStep();
      end
    end
  endtask

  task automatic compareLoop();
    bit ev;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("rst_rsp_err", 32'(rspErr), 32'd0);
        checkOutput("rst_rsp_rdata", rspRdata, 32'd0);
        checkOutput("rst_wr_err", 32'(wrErr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
      end else begin
        ev = (pRespAt == cyc);
        checkOutput("rsp_valid", 32'(rspValid), 32'(ev));
        checkOutput("rsp_err", 32'(rspErr), 32'(ev && pErr));
        if (ev && pKnown) checkOutput("rsp_rdata", rspRdata, pData);
        checkOutput("req_ready", 32'(reqReady), 32'(expReady(reqWrite)));
        checkOutput("wr_err", 32'(wrErr), 32'(wrErrAt == cyc));
        checkOutput("busy", 32'(busy),
                    32'((mQ.size() != 0) || ((pAccept < cyc) && (cyc <= pRespAt))));
      end
    end
  endtask

  // Drive one request and hold it until the DUT takes it; returns the stall count.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                               output int stalls);
    bit acc;
    reqValid = 1'b1; reqWrite = wr; reqAddr = addr; reqWdata = wd;
    stalls = 0; acc = 1'b0;
    for (int i = 0; i < 16 && !acc; i++) begin
      @(negedge clk);
      acc = reqReady;
      @(posedge clk); #1;
      if (!acc) stalls++;
    end
    reqValid = 1'b0; reqWrite = 1'b0;
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic doLoad(input string name, input logic [31:0] addr, input logic [31:0] expData,
                        input bit expErr, input int expLat, input bit checkLat);
    int st, lat;
    bit found;
    applyStimulus(1'b0, addr, 32'd0, st);
    found = 1'b0; lat = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (rspValid) begin
        found = 1'b1; lat = i;
      end
    end
    checkOutput({name, "_rsp_seen"}, 32'(found), 32'd1);
    if (found) begin
      if (checkLat) checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
      checkOutput({name, "_data"}, rspRdata, expData);
      checkOutput({name, "_err"}, 32'(rspErr), 32'(expErr));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int st;
    fork
      modelLoop();
      compareLoop();
    join_none

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_req_ready", 32'(reqReady), 32'd1);
    checkOutput("rel_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    $display("[TB] store then immediate load");
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, st);
    doLoad("t2", 32'h10, 32'hDEADBEEF, 1'b0, LAT_T2, 1'b1);

    $display("[TB] youngest store wins");
    applyStimulus(1'b1, 32'h20, 32'h1, st);
    applyStimulus(1'b1, 32'h20, 32'h2, st);
    doLoad("t3a", 32'h20, 32'h2, 1'b0, LAT_T3A, 1'b1);
    idle(4);
    doLoad("t3b", 32'h20, 32'h2, 1'b0, 2, 1'b1);

    $display("[TB] buffer full with valid held");
    idle(2);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h40 + 32'(4 * i), 32'h1000 + 32'(i), st);
      checkOutput($sformatf("t4_stall%0d", i), 32'(st), (i == 4) ? 32'd1 : 32'd0);
    end
    doLoad("t4_40", 32'h40, 32'h1000, 1'b0, LAT_T4, 1'b1);
    for (int i = 1; i < 5; i++) begin
      doLoad($sformatf("t4_%0d", i), 32'h40 + 32'(4 * i), 32'h1000 + 32'(i), 1'b0, 0, 1'b0);
    end

    $display("[TB] upper address bits wrap");
    applyStimulus(1'b1, 32'h0000_1040, 32'h77, st);
    doLoad("wrap_a", 32'h40, 32'h77, 1'b0, 0, 1'b0);
    doLoad("wrap_b", 32'hFFFF_F040, 32'h77, 1'b0, 0, 1'b0);

    $display("[TB] misaligned accesses");
    doLoad("t5_load", 32'h13, 32'h0, 1'b1, 1, 1'b1);
    idle(3);
    applyStimulus(1'b1, 32'h22, 32'h99, st);
    @(negedge clk);
    checkOutput("t5_wr_err_pulse", 32'(wrErr), 32'd1);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t5_wr_err_clear", 32'(wrErr), 32'd0);
    @(posedge clk); #1;
    doLoad("t5_unchanged", 32'h20, 32'h2, 1'b0, 2, 1'b1);

    $display("[TB] reset discards pending store");
    applyStimulus(1'b1, 32'h30, 32'hA5A5A5A5, st);
    idle(3);
    applyStimulus(1'b1, 32'h30, 32'h12345678, st);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t6_rel_ready", 32'(reqReady), 32'd1);
    checkOutput("t6_rel_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("t6_rel_wr_err", 32'(wrErr), 32'd0);
    checkOutput("t6_rel_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    doLoad("t6", 32'h30, 32'hA5A5A5A5, 1'b0, 2, 1'b1);

    idle(6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
